// File: rtl/acc_seq_pkg.sv
// acc_seq_pkg: shared types and helpers for the accelerator run-control sequencer.
// Provides the run state enum, mode encodings and the acc_sel width function.
package acc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    FAULT
  } seq_state_t;

  localparam logic MODE_PAR = 1'b0;
  localparam logic MODE_SEQ = 1'b1;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear and enable.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !(&count)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/acc_sequencer.sv
// acc_sequencer: turns a start press into parallel or sequential accelerator runs.
// Define ACC_SEQ_TIMEOUT_EN to build the hung-run comparator and FAULT state.
module acc_sequencer
  import acc_seq_pkg::*;
#(
  parameter int NUM_ACC        = 2,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          mode,
  output logic [NUM_ACC-1:0]            acc_start,
  input  logic [NUM_ACC-1:0]            acc_finish,
  output logic [sel_width(NUM_ACC)-1:0] acc_sel,
  output logic                          busy,
  output logic                          done,
  output logic                          timeout,
  output logic [CNT_WIDTH-1:0]          cycle_count
);

  localparam int SW = sel_width(NUM_ACC);

  seq_state_t         state;
  logic               start_q;
  logic               mode_q;
  logic [NUM_ACC-1:0] mask;
  logic [NUM_ACC-1:0] hit;
  logic               rise;
  logic               complete;
  logic               cnt_clr;
  logic               cnt_en;

  assign rise     = start & ~start_q;
  assign hit      = acc_start & acc_finish;
  assign complete = (state == RUN) && ((mask | hit) == '1);
  assign cnt_clr  = rise && (state != RUN);

`ifdef ACC_SEQ_TIMEOUT_EN
  logic tmo_fire;

  // Completion on the limit cycle takes priority over the timeout.
  assign tmo_fire = (state == RUN) && !complete &&
                    (cycle_count == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign cnt_en   = (state == RUN) && !tmo_fire;
`else
  logic unused_tmo;

  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign cnt_en     = (state == RUN);
  assign timeout    = 1'b0;
`endif

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(cnt_clr),
    .en   (cnt_en),
    .count(cycle_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      mode_q    <= MODE_PAR;
      mask      <= '0;
      acc_start <= '0;
      acc_sel   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef ACC_SEQ_TIMEOUT_EN
      timeout   <= 1'b0;
`endif
    end else begin
      start_q <= start;
      unique case (state)
        RUN: begin
          mask <= mask | hit;
          if (complete) begin
            state     <= DONE;
            acc_start <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
`ifdef ACC_SEQ_TIMEOUT_EN
          else if (tmo_fire) begin
            state     <= FAULT;
            acc_start <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b1;
          end
`endif
          else if (mode_q == MODE_SEQ) begin
            // Only channel acc_sel is live, so a shift hands off with no gap.
            acc_start <= (acc_start & ~hit) | (hit << 1);
            if (|hit) begin
              acc_sel <= acc_sel + SW'(1);
            end
          end else begin
            acc_start <= acc_start & ~hit;
          end
        end
        default: begin
          if (rise) begin
            state     <= RUN;
            mode_q    <= mode;
            mask      <= '0;
            acc_sel   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
`ifdef ACC_SEQ_TIMEOUT_EN
            timeout   <= 1'b0;
`endif
            acc_start <= (mode == MODE_SEQ) ? NUM_ACC'(1) : '1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_sequencer.sv
// tb_acc_sequencer: scoreboard bench for acc_sequencer with NUM_ACC=2.
// Expected run results are queued at stimulus time and popped when busy falls.
module tb_acc_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mode;
  logic [1:0]  acc_start;
  logic [1:0]  acc_finish;
  logic [0:0]  acc_sel;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] cycle_count;

  acc_sequencer #(
    .NUM_ACC       (2),
    .CNT_WIDTH     (32),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .acc_start  (acc_start),
    .acc_finish (acc_finish),
    .acc_sel    (acc_sel),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .cycle_count(cycle_count)
  );

  typedef struct {
    logic        d;
    logic        t;
    logic [31:0] c;
    logic        s;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cur     = 0;
  logic busy_d  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cur++;
  endtask

  task automatic rise(input logic m);
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cur   = 0;
  endtask

  task automatic go_to(input int c);
    while (cur < c) tick();
  endtask

  task automatic fin(input logic [1:0] v);
    acc_finish = v;
    tick();
    acc_finish = 2'b00;
  endtask

  task automatic push(input logic d, input logic t, input int c,
                      input logic s);
    exp_t e;
    e.d = d;
    e.t = t;
    e.c = c;
    e.s = s;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && busy_d && !busy) begin
      if (q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_done", done, e.d);
        chk("sb_timeout", timeout, e.t);
        chk("sb_count", cycle_count, e.c);
        chk("sb_sel", acc_sel, e.s);
      end
    end
    busy_d <= busy;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    mode       = 1'b0;
    acc_finish = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    chk("rst_start", acc_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", cycle_count, 0);

    // parallel run
    rise(1'b0);
    push(1, 0, 21, 0);
    chk("par_start0", acc_start, 2'b11);
    chk("par_busy", busy, 1);
    chk("par_count0", cycle_count, 0);
    go_to(10);
    chk("par_count10", cycle_count, 10);
    fin(2'b01);
    chk("par_start1", acc_start, 2'b10);
    chk("par_sel1", acc_sel, 0);
    go_to(20);
    fin(2'b10);
    chk("par_start2", acc_start, 2'b00);
    chk("par_done", done, 1);
    chk("par_busy_off", busy, 0);
    chk("par_count", cycle_count, 21);
    tick();
    tick();
    chk("par_hold", cycle_count, 21);

    // sequential run with idle-channel finish and mid-run rise
    rise(1'b1);
    push(1, 0, 13, 1);
    chk("seq_start0", acc_start, 2'b01);
    chk("seq_done_clr", done, 0);
    go_to(3);
    fin(2'b10);
    chk("seq_idle_fin", acc_start, 2'b01);
    go_to(5);
    fin(2'b01);
    chk("seq_start1", acc_start, 2'b10);
    chk("seq_sel1", acc_sel, 1);
    go_to(8);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_rise_count", cycle_count, 9);
    chk("mid_rise_start", acc_start, 2'b10);
    go_to(12);
    fin(2'b10);
    chk("seq_done", done, 1);
    chk("seq_count", cycle_count, 13);
    chk("seq_sel", acc_sel, 1);
    chk("seq_start2", acc_start, 2'b00);
    tick();

`ifdef ACC_SEQ_TIMEOUT_EN
    rise(1'b0);
    push(0, 1, 49, 0);
    go_to(49);
    chk("tmo_pre_busy", busy, 1);
    chk("tmo_pre_flag", timeout, 0);
    tick();
    chk("tmo_flag", timeout, 1);
    chk("tmo_start", acc_start, 2'b00);
    chk("tmo_count", cycle_count, 49);
    chk("tmo_done", done, 0);
    tick();
    chk("tmo_hold", cycle_count, 49);

    // restart from FAULT, then finish on the last legal cycle
    rise(1'b0);
    push(1, 0, 50, 0);
    chk("re_timeout", timeout, 0);
    chk("re_busy", busy, 1);
    chk("re_count", cycle_count, 0);
    go_to(30);
    fin(2'b01);
    go_to(49);
    fin(2'b10);
    chk("bnd_done", done, 1);
    chk("bnd_timeout", timeout, 0);
    chk("bnd_count", cycle_count, 50);
`else
    rise(1'b0);
    push(1, 0, 201, 0);
    go_to(200);
    chk("nt_busy", busy, 1);
    chk("nt_timeout", timeout, 0);
    chk("nt_count", cycle_count, 200);
    fin(2'b11);
    chk("nt_done", done, 1);
    chk("nt_count_end", cycle_count, 201);
`endif
    tick();

    // asynchronous reset mid-run
    rise(1'b1);
    go_to(7);
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    #2;
    chk("arst_start", acc_start, 0);
    chk("arst_sel", acc_sel, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_timeout", timeout, 0);
    chk("arst_count", cycle_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    fin(2'b11);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    // short parallel run out of IDLE, both finishes in one cycle
    rise(1'b0);
    push(1, 0, 3, 0);
    chk("post_start", acc_start, 2'b11);
    go_to(2);
    fin(2'b11);
    chk("post_done", done, 1);
    tick();
    tick();

    chk("sb_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
